muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32 M-extension unit: 32-step shift-add multiply and restoring divide,
// with single-cycle bypass for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      fsm_state
);

  // Handshake: a request is accepted on any edge where the FSM is IDLE, start=1 and
  // flush=0; start is ignored in every other state.  done is a one-cycle pulse and
  // result is valid in that cycle; there is no back-pressure on done.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  op;
  logic        neg_a;
  logic        neg_b;
  logic [63:0] mcand;
  logic [63:0] acc;
  logic [31:0] opb;

  logic        a_signed_in, b_signed_in, sa_in, sb_in;
  logic [31:0] mag_a, mag_b;
  logic        div_zero, div_ovf;
  logic [31:0] bypass_res;

  always_comb begin
    a_signed_in = (func3 == 3'b001) || (func3 == 3'b010) ||
                  (func3 == 3'b100) || (func3 == 3'b110);
    b_signed_in = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
    sa_in       = a_signed_in & rs1[31];
    sb_in       = b_signed_in & rs2[31];
    mag_a       = sa_in ? (~rs1 + 32'd1) : rs1;
    mag_b       = sb_in ? (~rs2 + 32'd1) : rs2;
    div_zero    = func3[2] && (rs2 == 32'd0);
    div_ovf     = ((func3 == 3'b100) || (func3 == 3'b110)) &&
                  (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    bypass_res  = 32'd0;
    if (div_zero)
      bypass_res = func3[1] ? rs1 : 32'hFFFF_FFFF;
    else if (div_ovf)
      bypass_res = func3[1] ? 32'd0 : 32'h8000_0000;
  end

  // One radix-2 step.  For divide, acc holds {remainder, dividend/quotient}.
  logic [63:0] mul_acc_nxt, div_acc_nxt, acc_nxt, prod;
  logic [32:0] trial;
  logic [31:0] quo, rem, final_res;

  always_comb begin
    mul_acc_nxt = opb[0] ? (acc + mcand) : acc;
    trial       = acc[63:31] - {1'b0, opb};
    div_acc_nxt = trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
    acc_nxt     = op[2] ? div_acc_nxt : mul_acc_nxt;
    prod        = (neg_a ^ neg_b) ? (~acc_nxt + 64'd1) : acc_nxt;
    quo         = acc_nxt[31:0];
    rem         = acc_nxt[63:32];
    final_res   = 32'd0;
    case (op)
      3'b000:         final_res = prod[31:0];
      3'b001, 3'b010,
      3'b011:         final_res = prod[63:32];
      3'b100, 3'b101: final_res = (neg_a ^ neg_b) ? (~quo + 32'd1) : quo;
      default:        final_res = neg_a ? (~rem + 32'd1) : rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 32'd0;
      op     <= 3'd0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      mcand  <= 64'd0;
      acc    <= 64'd0;
      opb    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !flush) begin
            op    <= func3;
            neg_a <= sa_in;
            neg_b <= sb_in;
            if (div_zero || div_ovf) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= bypass_res;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              cnt   <= 5'd0;
              mcand <= {32'd0, mag_a};
              opb   <= mag_b;
              acc   <= func3[2] ? {32'd0, mag_a} : 64'd0;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 5'd0;
          end else begin
            acc   <= acc_nxt;
            mcand <= mcand << 1;
            opb   <= op[2] ? opb : (opb >> 1);
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= final_res;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign stall     = (state == CALC) || ((state == IDLE) && start && !flush);
  assign fsm_state = state;

endmodule
